// File: rtl/concat.sv
// UART word-length formatter: zero-extends the active WLS bits of a byte,
// registers it, and reports even parity and whether discarded bits were set.
module concat (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] WLS,
    input  logic [7:0] data_in,
    input  logic       in_valid,
    output logic [7:0] data_out,
    output logic       out_valid,
    output logic       parity,
    output logic       trunc
);

    logic [7:0] keep_mask;
    logic [7:0] formatted;
    logic       formatted_parity;
    logic       dropped_any;

    // An unknown WLS falls to the narrowest mask so no stray high bits escape.
    always_comb begin
        keep_mask = 8'b0001_1111;
        case (WLS)
            2'b00:   keep_mask = 8'b0001_1111;
            2'b01:   keep_mask = 8'b0011_1111;
            2'b10:   keep_mask = 8'b0111_1111;
            2'b11:   keep_mask = 8'b1111_1111;
            default: keep_mask = 8'b0001_1111;
        endcase
    end

    assign formatted        = data_in & keep_mask;
    assign formatted_parity = ^formatted;
    assign dropped_any      = |(data_in & ~keep_mask);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out  <= 8'h00;
            parity    <= 1'b0;
            trunc     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                data_out <= formatted;
                parity   <= formatted_parity;
                trunc    <= dropped_any;
            end
        end
    end

endmodule

// File: tb/tb_concat.sv
// Directed-vector and randomized bench for the concat word-length formatter.
module tb_concat;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] WLS;
    logic [7:0] data_in;
    logic       in_valid;
    logic [7:0] data_out;
    logic       out_valid;
    logic       parity;
    logic       trunc;

    int n_compared   = 0;
    int n_mismatched = 0;

    concat dut (
        .clk       (clk),
        .rst       (rst),
        .WLS       (WLS),
        .data_in   (data_in),
        .in_valid  (in_valid),
        .data_out  (data_out),
        .out_valid (out_valid),
        .parity    (parity),
        .trunc     (trunc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] wls;
        logic [7:0] din;
        logic [7:0] exp_dout;
        logic       exp_par;
        logic       exp_trunc;
    } vec_t;

    task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("FAIL %s: got %02h, expected %02h", name, actual, expected);
        end
    endtask

    // Reference: bit-by-bit walk over the word length, independent of any mask table.
    function automatic void model(input logic [1:0] w, input logic [7:0] d,
                                  output logic [7:0] o, output logic p, output logic t);
        int len;
        len = 5 + int'(w);
        o = 8'h00; p = 1'b0; t = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < len) begin
                o[i] = d[i];
                p    = p ^ d[i];
            end else begin
                t = t | d[i];
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, " data_out"},  data_out, 8'h00);
        check({tag, " parity"},    {7'b0, parity}, 8'h00);
        check({tag, " trunc"},     {7'b0, trunc}, 8'h00);
        check({tag, " out_valid"}, {7'b0, out_valid}, 8'h00);
    endtask

    vec_t vecs[10];

    initial begin
        logic [7:0] exp_o, held;
        logic       exp_p, exp_t;
        logic [1:0] prev_w;
        logic [7:0] prev_d;
        int         len;

        vecs[0] = '{2'b00, 8'hFF, 8'b0001_1111, 1'b1, 1'b1};
        vecs[1] = '{2'b01, 8'hFF, 8'b0011_1111, 1'b0, 1'b1};
        vecs[2] = '{2'b10, 8'hFF, 8'b0111_1111, 1'b1, 1'b1};
        vecs[3] = '{2'b11, 8'hFF, 8'b1111_1111, 1'b0, 1'b0};
        vecs[4] = '{2'b00, 8'b0001_0101, 8'b0001_0101, 1'b1, 1'b0};
        vecs[5] = '{2'b10, 8'hA5, 8'h25, 1'b1, 1'b1};
        vecs[6] = '{2'b01, 8'h40, 8'h00, 1'b0, 1'b1};
        vecs[7] = '{2'b11, 8'h80, 8'h80, 1'b1, 1'b0};
        vecs[8] = '{2'b00, 8'hE0, 8'h00, 1'b0, 1'b1};
        vecs[9] = '{2'b01, 8'h21, 8'h21, 1'b0, 1'b0};

        rst = 1'b1; WLS = 2'b00; data_in = 8'h00; in_valid = 1'b0;
        #2;
        check_zero("reset");
        step();
        rst = 1'b0;

        // Back-to-back table vectors: result appears one edge after drive.
        for (int i = 0; i < 10; i++) begin
            WLS = vecs[i].wls; data_in = vecs[i].din; in_valid = 1'b1;
            step();
            check($sformatf("vec%0d data_out", i), data_out, vecs[i].exp_dout);
            check($sformatf("vec%0d parity", i), {7'b0, parity}, {7'b0, vecs[i].exp_par});
            check($sformatf("vec%0d trunc", i), {7'b0, trunc}, {7'b0, vecs[i].exp_trunc});
            check($sformatf("vec%0d out_valid", i), {7'b0, out_valid}, 8'h01);
        end

        // Hold: WLS/data_in wiggle without in_valid must not disturb the result.
        WLS = 2'b10; data_in = 8'hA5; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        held = data_out;
        check("hold capture", held, 8'h25);
        for (int i = 0; i < 5; i++) begin
            WLS = 2'(i); data_in = 8'hFF ^ 8'(i * 37);
            step();
            check($sformatf("hold%0d data_out", i), data_out, 8'h25);
            check($sformatf("hold%0d parity", i), {7'b0, parity}, 8'h01);
            check($sformatf("hold%0d trunc", i), {7'b0, trunc}, 8'h01);
            check($sformatf("hold%0d out_valid", i), {7'b0, out_valid}, 8'h00);
        end

        // Random back-to-back stream.
        WLS = 2'($urandom_range(0, 3)); data_in = 8'($urandom_range(0, 255)); in_valid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            prev_w = WLS; prev_d = data_in;
            step();
            model(prev_w, prev_d, exp_o, exp_p, exp_t);
            len = 5 + int'(prev_w);
            check("rnd data_out", data_out, exp_o);
            check("rnd parity", {7'b0, parity}, {7'b0, exp_p});
            check("rnd trunc", {7'b0, trunc}, {7'b0, exp_t});
            check("rnd out_valid", {7'b0, out_valid}, 8'h01);
            check("rnd high bits", data_out >> len, 8'h00);
            WLS = 2'($urandom_range(0, 3)); data_in = 8'($urandom_range(0, 255));
        end

        // Mid-stream asynchronous reset with a valid result showing.
        WLS = 2'b00; data_in = 8'hFF; in_valid = 1'b1;
        step();
        check("pre-reset out_valid", {7'b0, out_valid}, 8'h01);
        check("pre-reset data_out", data_out, 8'h1F);
        #2 rst = 1'b1;
        #1;
        check_zero("async reset");
        // Reset wins over a concurrent in_valid.
        step();
        check_zero("reset vs valid");
        rst = 1'b0;
        in_valid = 1'b0;
        step();
        check_zero("post-release idle");

        // First capture right after release.
        WLS = 2'b11; data_in = 8'hC3; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("first capture data_out", data_out, 8'hC3);
        check("first capture parity", {7'b0, parity}, 8'h00);
        check("first capture trunc", {7'b0, trunc}, 8'h00);
        check("first capture out_valid", {7'b0, out_valid}, 8'h01);
        step();
        check("pulse drop out_valid", {7'b0, out_valid}, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
